// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin sharing of one 8N1 UART transmitter among N_REQ requesters.
// Define UART_TX_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module uart_tx_sched #(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 10,
  parameter int PTR_W        = 2
) (
  input  logic               i_clk_tx,
  input  logic               i_reset,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_ack,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  output logic               o_busy,
  output logic [PTR_W-1:0]   o_grant_id
);
  localparam logic [1:0] S_IDLE = 2'd0, S_LAUNCH = 2'd1, S_BUSY = 2'd2;
  localparam int CNT_W = $clog2(FRAME_CYCLES + 1);
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_ptr;
  logic [N_REQ-1:0] r_ack;
  logic [7:0]       r_data;
  logic [PTR_W-1:0] w_win;
  logic [7:0]       w_byte;
  logic             w_arb;
  int               w_best;
  int               w_dist;
  assign w_arb      = (r_state == S_IDLE) || (r_state == S_BUSY && r_cnt == CNT_W'(FRAME_CYCLES));
  assign o_ack      = r_ack;
  assign o_tx_start = (r_state == S_LAUNCH);
  assign o_tx_data  = r_data;
  assign o_busy     = (r_state != S_IDLE);
  assign o_grant_id = r_ptr;
  // Winner is the asserted request at the smallest distance past the pointer.
  always_comb begin
    w_win  = '0;
    w_byte = '0;
    w_best = N_REQ;
    w_dist = 0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
      w_dist = k;
`else
      w_dist = (k + N_REQ - 1 - int'(r_ptr)) % N_REQ;
`endif
      if (i_req[k] && w_dist < w_best) begin
        w_best = w_dist;
        w_win  = PTR_W'(k);
        w_byte = i_req_data[8*k +: 8];
      end
    end
  end
  always_ff @(posedge i_clk_tx) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= PTR_W'(N_REQ - 1);
      r_ack   <= '0;
      r_data  <= 8'h00;
    end else begin
      r_ack <= '0;
      if (w_arb && |i_req) begin
        r_state <= S_LAUNCH;
        r_data  <= w_byte;
        r_ack   <= N_REQ'(1) << w_win;
        r_ptr   <= w_win;
        r_cnt   <= '0;
      end else if (w_arb || r_state == S_IDLE || r_state > S_BUSY) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (r_state == S_LAUNCH) begin
        r_state <= S_BUSY;
        r_cnt   <= CNT_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed checks of uart_tx_sched with a small 8N1 transmitter model on the line.
module tb_uart_tx_sched;
  logic        clk = 0;
  logic        reset = 1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;
  int          checks = 0;
  int          failures = 0;
  int          tx_st = 0;
  logic        line;
  uart_tx_sched dut (
    .i_clk_tx(clk), .i_reset(reset), .i_req(req), .i_req_data(req_data),
    .o_ack(ack), .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy), .o_grant_id(grant_id)
  );
  always #5 clk = ~clk;
  // Transmitter model: idle, start, d0..d7, stop; reads data combinationally.
  always @(posedge clk) begin
    if (reset) tx_st <= 0;
    else if (tx_st == 0) tx_st <= tx_start ? 1 : 0;
    else if (tx_st == 10) tx_st <= 0;
    else tx_st <= tx_st + 1;
  end
  assign line = (tx_st == 0) ? 1'b1 : (tx_st == 1) ? 1'b0 : (tx_st == 10) ? 1'b1 : tx_data[tx_st-2];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_start(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_start && n < 40);
  endtask
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask
  task automatic collect(input logic [7:0] exp, output logic [9:0] lb, output int bad, output int extra);
    bad = 0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lb[i] = line;
      if (tx_data !== exp) bad++;
      if (tx_start || ack != 0) extra++;
    end
  endtask
  initial begin
    int n, bad, extra;
    logic [9:0] lb;
    // Reset state
    tick(); tick();
    chk("rst_ack", ack, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 3);
    // Single request, byte A5
    req = 4'b0001; req_data = 32'h0000_00A5;
    reset = 0;
    tick();
    chk("t1_start", tx_start, 1);
    chk("t1_ack", ack, 4'b0001);
    chk("t1_grant", grant_id, 0);
    chk("t1_busy", busy, 1);
    req = 4'b0000;
    collect(8'hA5, lb, bad, extra);
    chk("t1_data_held", bad, 0);
    chk("t1_one_pulse", extra, 0);
    chk("t1_line", lb, 10'b1101001010);
    tick();
    chk("t1_idle", busy, 0);
    // All four requesting continuously
    reset = 1; tick();
    req = 4'b1111; req_data = 32'h4433_2211;
    reset = 0;
    tick();
    chk("t2_g0", grant_id, 0);
    chk("t2_d0", tx_data, 8'h11);
    wait_start(n); chk("t2_gap1", n, 11); chk("t2_g1", grant_id, 1); chk("t2_d1", tx_data, 8'h22);
    wait_start(n); chk("t2_gap2", n, 11); chk("t2_g2", grant_id, 2); chk("t2_d2", tx_data, 8'h33);
    wait_start(n); chk("t2_gap3", n, 11); chk("t2_g3", grant_id, 3); chk("t2_d3", tx_data, 8'h44);
    wait_start(n); chk("t2_gap4", n, 11); chk("t2_g4", grant_id, 0); chk("t2_ack4", ack, 4'b0001);
    req = 4'b0000;
    wait_idle("t2_idle");
    // Requester 2 holds, requester 1 requests once
    req = 4'b0100;
    wait_start(n); chk("t3_g0", grant_id, 2);
    req = 4'b0110;
    wait_start(n); chk("t3_gap1", n, 11); chk("t3_g1", grant_id, 1); chk("t3_ack1", ack, 4'b0010);
    req = 4'b0100;
    wait_start(n); chk("t3_gap2", n, 11); chk("t3_g2", grant_id, 2);
    req = 4'b0000;
    wait_idle("t3_idle");
    // Byte changes right after capture
    req = 4'b0001; req_data = 32'h0000_005A;
    wait_start(n); chk("t4_grant", grant_id, 0); chk("t4_data", tx_data, 8'h5A);
    req = 4'b0000; req_data = 32'h0000_00FF;
    collect(8'h5A, lb, bad, extra);
    chk("t4_data_held", bad, 0);
    chk("t4_line", lb, 10'b1010110100);
    wait_idle("t4_idle");
    // Reset in BUSY at counter 5 with a pending request
    req = 4'b0001; req_data = 32'h0000_0077;
    wait_start(n);
    req = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_busy_before", busy, 1);
    reset = 1; req = 4'b1000;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_data", tx_data, 8'h00);
    chk("t5_start", tx_start, 0);
    chk("t5_grant", grant_id, 3);
    chk("t5_line", line, 1);
    reset = 0;
    tick();
    chk("t5_regrant", tx_start, 1);
    chk("t5_regrant_id", grant_id, 3);
    chk("t5_regrant_ack", ack, 4'b1000);
    req = 4'b0000;
    wait_idle("t5_idle");
    // Requesters 0 and 3 held continuously
    reset = 1; tick();
    req = 4'b1001; req_data = 32'hD000_00C0;
    reset = 0;
    tick();
    chk("t6_g0", grant_id, 0);
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    wait_start(n); chk("t6_g1", grant_id, 0);
    wait_start(n); chk("t6_g2", grant_id, 0);
`else
    wait_start(n); chk("t6_g1", grant_id, 3); chk("t6_d1", tx_data, 8'hD0);
    wait_start(n); chk("t6_g2", grant_id, 0); chk("t6_d2", tx_data, 8'hC0);
`endif
    req = 4'b0000;
    wait_idle("t6_idle");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
